// File: rtl/usb_sync_pkg.sv
// ============================================================================
// Module      : usb_sync_pkg
// Description : Shared types and helpers for the usb_syncfilt synchroniser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_sync_pkg;

    typedef enum logic [0:0] {
        FILT_IDLE = 1'b0,
        FILT_QUAL = 1'b1
    } filt_state_t;

    // Wide enough to hold FILT_CYCLES itself, so cnt+1 never wraps.
    function automatic int cnt_width(input int filt_cycles);
        return $clog2(filt_cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/usb_syncfilt_chan.sv
// ============================================================================
// Module      : usb_syncfilt_chan
// Description : One channel: synchroniser chain, stability filter, strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_syncfilt_chan
    import usb_sync_pkg::*;
#(
    parameter int   STAGES      = 2,
    parameter int   FILT_CYCLES = 4,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clock,
    input  logic reset0_sync,
    input  logic datain_async,
    output logic dataout_sync,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int              CNT_W    = cnt_width(FILT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    logic [STAGES-1:0] sync_q, sync_d;
    filt_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dout_q, dout_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              sy;
    logic              update;

    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], datain_async};
        sy      = sync_q[STAGES-1];
        state_d = state_q;
        cnt_d   = cnt_q;
        update  = 1'b0;

        case (state_q)
            FILT_IDLE: begin
                if (sy != dout_q) begin
                    // The first differing edge already counts as one qualifying cycle.
                    if (CNT_LAST == '0) begin
                        update = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = FILT_QUAL;
                    end
                end
            end
            FILT_QUAL: begin
                if (sy == dout_q) begin
                    cnt_d   = '0;
                    state_d = FILT_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    update  = 1'b1;
                    cnt_d   = '0;
                    state_d = FILT_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = FILT_IDLE;
            end
        endcase

        dout_d = update ? sy : dout_q;
        rise_d = update & sy;
        fall_d = update & ~sy;
    end

    always_ff @(posedge clock) begin
        if (!reset0_sync) begin
            sync_q  <= {STAGES{RST_VAL}};
            state_q <= FILT_IDLE;
            cnt_q   <= '0;
            dout_q  <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dataout_sync = dout_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;

endmodule

`default_nettype wire

// File: rtl/usb_syncfilt.sv
// ============================================================================
// Module      : usb_syncfilt
// Description : Multi-channel async-input synchroniser with glitch filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_syncfilt
    import usb_sync_pkg::*;
#(
    parameter int                  CHANNELS    = 3,
    parameter int                  STAGES      = 2,
    parameter int                  FILT_CYCLES = 4,
    parameter logic [CHANNELS-1:0] DATA_ONRST  = '0
) (
    input  logic                clock,
    input  logic                reset0_sync,
    input  logic [CHANNELS-1:0] datain_async,
    output logic [CHANNELS-1:0] dataout_sync,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        usb_syncfilt_chan #(
            .STAGES      (STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .RST_VAL     (DATA_ONRST[i])
        ) u_chan (
            .clock        (clock),
            .reset0_sync  (reset0_sync),
            .datain_async (datain_async[i]),
            .dataout_sync (dataout_sync[i]),
            .rise_pulse   (rise_pulse[i]),
            .fall_pulse   (fall_pulse[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_usb_syncfilt.sv
// ============================================================================
// Module      : tb_usb_syncfilt
// Description : Directed self-checking bench for usb_syncfilt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_syncfilt;

    logic       clock = 1'b0;
    logic       rst_a, rst_b;
    logic [2:0] din_a, din_b;
    logic [2:0] dout_a, rise_a, fall_a;
    logic [2:0] dout_b, rise_b, fall_b;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    usb_syncfilt #(
        .CHANNELS(3), .STAGES(2), .FILT_CYCLES(4), .DATA_ONRST(3'b000)
    ) u_dut_a (
        .clock        (clock),
        .reset0_sync  (rst_a),
        .datain_async (din_a),
        .dataout_sync (dout_a),
        .rise_pulse   (rise_a),
        .fall_pulse   (fall_a)
    );

    usb_syncfilt #(
        .CHANNELS(3), .STAGES(3), .FILT_CYCLES(1), .DATA_ONRST(3'b101)
    ) u_dut_b (
        .clock        (clock),
        .reset0_sync  (rst_b),
        .datain_async (din_b),
        .dataout_sync (dout_b),
        .rise_pulse   (rise_b),
        .fall_pulse   (fall_b)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_a(input string tag, input logic [2:0] d, input logic [2:0] r,
                           input logic [2:0] f);
        check({tag, ".dout"}, dout_a, d);
        check({tag, ".rise"}, rise_a, r);
        check({tag, ".fall"}, fall_a, f);
    endtask

    task automatic check_b(input string tag, input logic [2:0] d, input logic [2:0] r,
                           input logic [2:0] f);
        check({tag, ".dout"}, dout_b, d);
        check({tag, ".rise"}, rise_b, r);
        check({tag, ".fall"}, fall_b, f);
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        din_a = 3'b111;
        din_b = 3'b010;

        // Reset held for three cycles with all inputs high
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_a("rst", 3'b000, 3'b000, 3'b000);
            check_b("rst_b", 3'b101, 3'b000, 3'b000);
        end

        // ch0 rises: six edges from the first sampling edge
        rst_a = 1'b1;
        din_a = 3'b001;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_a("ch0_wait", 3'b000, 3'b000, 3'b000);
        end
        step(1);
        check_a("ch0_rise", 3'b001, 3'b001, 3'b000);
        step(1);
        check_a("ch0_hold", 3'b001, 3'b000, 3'b000);

        // ch1 glitch of three synced cycles is rejected
        din_a = 3'b011;
        step(3);
        din_a = 3'b001;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check_a("ch1_glitch", 3'b001, 3'b000, 3'b000);
        end

        // ch1 held long enough qualifies
        din_a = 3'b011;
        step(5);
        check_a("ch1_wait", 3'b001, 3'b000, 3'b000);
        step(1);
        check_a("ch1_rise", 3'b011, 3'b010, 3'b000);

        // ch0 falls and ch2 rises on the same edge
        step(2);
        din_a = 3'b110;
        step(5);
        check_a("dual_wait", 3'b011, 3'b000, 3'b000);
        step(1);
        check_a("dual_edge", 3'b110, 3'b100, 3'b001);
        step(1);
        check_a("dual_hold", 3'b110, 3'b000, 3'b000);

        // ch2 back low so it can rise again below
        din_a = 3'b010;
        step(6);
        check_a("ch2_fall", 3'b010, 3'b000, 3'b100);

        // ch0 toggling every cycle never qualifies
        for (int i = 0; i < 12; i++) begin
            din_a = (i % 2 == 0) ? 3'b011 : 3'b010;
            step(1);
            check("toggle.dout", dout_a, 3'b010);
        end
        din_a = 3'b010;
        step(8);
        check_a("toggle_end", 3'b010, 3'b000, 3'b000);

        // ch2 rises, reset lands on the 4th edge
        din_a = 3'b110;
        step(3);
        check_a("midq_pre", 3'b010, 3'b000, 3'b000);
        rst_a = 1'b0;
        step(1);
        check_a("midq_rst", 3'b000, 3'b000, 3'b000);

        // Release with only ch2 high: qualified from reset value
        rst_a = 1'b1;
        din_a = 3'b100;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_a("rel_wait", 3'b000, 3'b000, 3'b000);
        end
        step(1);
        check_a("rel_rise", 3'b100, 3'b100, 3'b000);
        step(1);
        check_a("rel_hold", 3'b100, 3'b000, 3'b000);

        // Second configuration: STAGES=3, no filtering, reset value 101
        din_b = 3'b101;
        rst_b = 1'b1;
        step(4);
        check_b("b_idle", 3'b101, 3'b000, 3'b000);
        din_b = 3'b111;
        step(3);
        check_b("b_rise_wait", 3'b101, 3'b000, 3'b000);
        step(1);
        check_b("b_rise", 3'b111, 3'b010, 3'b000);
        din_b = 3'b010;
        step(3);
        check_b("b_fall_wait", 3'b111, 3'b000, 3'b000);
        step(1);
        check_b("b_fall", 3'b010, 3'b000, 3'b101);
        step(1);
        check_b("b_hold", 3'b010, 3'b000, 3'b000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
